// File: rtl/grid_sprite_render.sv
// Grid-aligned sprite renderer: NSPR cell-sized sprites with shadow/active
// registers committed at frame start, a 2-stage hit/priority pipeline, and registered rgbout.

module gsr_lane #(
  parameter int CELL_LOG2 = 5,
  parameter int X_BITS    = 5,
  parameter int Y_BITS    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              commit,
  input  logic [X_BITS-1:0] wx,
  input  logic [Y_BITS-1:0] wy,
  input  logic [7:0]        wcolor,
  input  logic [1:0]        wmode,
  input  logic [10:0]       hcount,
  input  logic [10:0]       vcount,
  input  logic              blink_on,
  output logic              hit_q,
  output logic [7:0]        color_q
);
  typedef struct packed {
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
    logic [7:0]        color;
    logic [1:0]        mode;
  } spr_t;

  // Wide enough that the last column/row upper bound never wraps.
  localparam int XW  = X_BITS + CELL_LOG2 + 1;
  localparam int YW  = Y_BITS + CELL_LOG2 + 1;
  localparam int CW0 = (XW > 12) ? XW : 12;
  localparam int CW  = (YW > CW0) ? YW : CW0;
  localparam logic [CW-1:0] SPAN = CW'((1 << CELL_LOG2) - 1);

  spr_t shadow, active;
  logic [CW-1:0] hx, vy, xlo, xhi, ylo, yhi;
  logic [CELL_LOG2-1:0] hl, vl;
  logic in_cell, on_edge, hit_c;

  assign hx  = CW'(hcount);
  assign vy  = CW'(vcount);
  assign xlo = CW'(active.x) << CELL_LOG2;
  assign ylo = CW'(active.y) << CELL_LOG2;
  assign xhi = xlo + SPAN;
  assign yhi = ylo + SPAN;
  assign hl  = hcount[CELL_LOG2-1:0];
  assign vl  = vcount[CELL_LOG2-1:0];

  always_comb begin
    in_cell = (hx >= xlo) && (hx <= xhi) && (vy >= ylo) && (vy <= yhi);
    on_edge = (hl == '0) || (&hl) || (vl == '0) || (&vl);
    hit_c   = 1'b0;
    case (active.mode)
      2'b01:   hit_c = in_cell;
      2'b10:   hit_c = in_cell && on_edge;
      2'b11:   hit_c = in_cell && blink_on;
      default: hit_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      hit_q   <= 1'b0;
      color_q <= '0;
    end else begin
      if (we)     shadow <= '{x: wx, y: wy, color: wcolor, mode: wmode};
      if (commit) active <= shadow;
      hit_q   <= hit_c;
      color_q <= active.color;
    end
  end
endmodule

module grid_sprite_render #(
  parameter int CELL_LOG2  = 5,
  parameter int X_BITS     = 5,
  parameter int Y_BITS     = 4,
  parameter int NSPR       = 4,
  parameter int BLINK_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       hcount,
  input  logic [10:0]       vcount,
  input  logic              blank,
  input  logic              wr_en,
  input  logic [2:0]        wr_idx,
  input  logic [X_BITS-1:0] wr_x,
  input  logic [Y_BITS-1:0] wr_y,
  input  logic [7:0]        wr_color,
  input  logic [1:0]        wr_mode,
  output logic              wr_ready,
  output logic              dirty,
  output logic [7:0]        rgbout
);
  logic commit, accept, blank_s1;
  logic [BLINK_LOG2:0] blink_cnt;
  logic [NSPR-1:0] hit_s1;
  logic [NSPR-1:0][7:0] color_s1;
  logic [7:0] sel;

  assign commit   = (hcount == 11'd0) && (vcount == 11'd0);
  // Held high through reset even if the counters sit at the commit pixel.
  assign wr_ready = !(commit && rst_n);
  assign accept   = wr_en && wr_ready;

  for (genvar i = 0; i < NSPR; i++) begin : g_lane
    gsr_lane #(.CELL_LOG2(CELL_LOG2), .X_BITS(X_BITS), .Y_BITS(Y_BITS)) u_lane (
      .clk(clk), .rst_n(rst_n),
      .we(accept && (wr_idx == 3'(i))), .commit(commit),
      .wx(wr_x), .wy(wr_y), .wcolor(wr_color), .wmode(wr_mode),
      .hcount(hcount), .vcount(vcount), .blink_on(!blink_cnt[BLINK_LOG2]),
      .hit_q(hit_s1[i]), .color_q(color_s1[i])
    );
  end

  always_comb begin
    sel = '0;
    for (int i = NSPR - 1; i >= 0; i--)
      if (hit_s1[i]) sel = color_s1[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_s1  <= 1'b0;
      rgbout    <= '0;
      blink_cnt <= '0;
      dirty     <= 1'b0;
    end else begin
      blank_s1 <= blank;
      rgbout   <= blank_s1 ? 8'h00 : sel;
      if (commit) begin
        blink_cnt <= blink_cnt + 1'b1;
        dirty     <= 1'b0;
      end else if (accept) begin
        dirty <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_grid_sprite_render.sv
// Directed scoreboard bench for grid_sprite_render: pixel vectors push expected
// colours; a monitor pops them two clocks later and compares against rgbout.

module tb_grid_sprite_render;
  logic clk = 0, rst_n = 0;
  logic [10:0] hcount = 0, vcount = 0;
  logic blank = 1, wr_en = 0;
  logic [2:0] wr_idx = 0;
  logic [4:0] wr_x = 0;
  logic [3:0] wr_y = 0;
  logic [7:0] wr_color = 0;
  logic [1:0] wr_mode = 0;
  logic wr_ready, dirty;
  logic [7:0] rgbout;

  int n_vec = 0, n_err = 0;
  logic [4:0] bcnt = 0;

  typedef struct { bit chk; logic [7:0] exp; string name; } ent_t;
  ent_t q[$];
  ent_t prev;
  bit prev_v = 0;

  grid_sprite_render dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .blank(blank),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .wr_mode(wr_mode), .wr_ready(wr_ready), .dirty(dirty), .rgbout(rgbout)
  );

  always #5 clk = ~clk;

  function automatic void cmp(string name, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Entry popped at edge k describes inputs sampled at k; rgbout for it appears after edge k+1.
  always @(posedge clk) begin
    #1;
    if (!rst_n) prev_v = 0;
    else begin
      if (prev_v && prev.chk) cmp(prev.name, rgbout, prev.exp);
      if (q.size() > 0) begin prev = q.pop_front(); prev_v = 1; end
      else prev_v = 0;
    end
  end

  task automatic pix(input int h, input int v, input bit b, input bit chk,
                     input logic [7:0] exp, input string name);
    ent_t e;
    @(negedge clk);
    hcount = 11'(h); vcount = 11'(v); blank = b;
    e.chk = chk; e.exp = exp; e.name = name;
    q.push_back(e);
  endtask

  task automatic commit_frame();
    pix(0, 0, 1, 0, 8'h00, "");
    bcnt++;
    pix(5, 5, 1, 0, 8'h00, "");
  endtask

  task automatic wr(input int idx, input int x, input int y, input logic [7:0] c,
                    input logic [1:0] m);
    @(negedge clk);
    wr_en = 1; wr_idx = 3'(idx); wr_x = 5'(x); wr_y = 4'(y); wr_color = c; wr_mode = m;
    @(negedge clk);
    wr_en = 0;
  endtask

  initial begin
    // Reset with counters parked at the commit pixel: wr_ready must still read 1.
    #2;
    cmp("rst_rgb", rgbout, 8'h00);
    cmp("rst_dirty", {7'd0, dirty}, 8'h00);
    cmp("rst_ready", {7'd0, wr_ready}, 8'h01);
    @(negedge clk); hcount = 5; vcount = 5;
    @(negedge clk); rst_n = 1;

    // Single solid sprite at cell (2,1)
    wr(0, 2, 1, 8'hE0, 2'b01);
    #1 cmp("dirty_after_wr", {7'd0, dirty}, 8'h01);
    pix(70, 40, 0, 1, 8'h00, "pre_commit");
    commit_frame();
    #1 cmp("dirty_after_commit", {7'd0, dirty}, 8'h00);
    pix(64, 32, 0, 1, 8'hE0, "solid_tl");
    pix(95, 63, 0, 1, 8'hE0, "solid_br");
    pix(63, 40, 0, 1, 8'h00, "solid_h63");
    pix(96, 40, 0, 1, 8'h00, "solid_h96");
    pix(80, 31, 0, 1, 8'h00, "solid_v31");
    pix(80, 64, 0, 1, 8'h00, "solid_v64");
    pix(70, 40, 1, 1, 8'h00, "blank_in_cell");

    // Priority: ch0 beats ch1 on the same cell
    wr(0, 0, 0, 8'h1C, 2'b01);
    wr(1, 0, 0, 8'h03, 2'b01);
    commit_frame();
    pix(10, 10, 0, 1, 8'h1C, "prio_ch0");
    pix(70, 40, 0, 1, 8'h00, "old_pos_gone");
    wr(0, 0, 0, 8'h1C, 2'b00);
    commit_frame();
    pix(10, 10, 0, 1, 8'h03, "prio_ch1");

    // Mid-frame write stays in shadow until commit
    wr(1, 0, 0, 8'h55, 2'b01);
    #1 cmp("dirty_mid_frame", {7'd0, dirty}, 8'h01);
    pix(10, 10, 0, 1, 8'h03, "old_colour");
    commit_frame();
    pix(10, 10, 0, 1, 8'h55, "new_colour");
    pix(31, 31, 0, 1, 8'h55, "cell_corner");

    // Write held across the commit cycle
    @(negedge clk);
    hcount = 0; vcount = 0; blank = 1;
    wr_en = 1; wr_idx = 2; wr_x = 1; wr_y = 0; wr_color = 8'h77; wr_mode = 2'b01;
    #1 cmp("ready_on_commit", {7'd0, wr_ready}, 8'h00);
    bcnt++;
    @(negedge clk); hcount = 5; vcount = 5;
    #1 cmp("ready_after_commit", {7'd0, wr_ready}, 8'h01);
    @(negedge clk); wr_en = 0;
    #1 cmp("dirty_held_wr", {7'd0, dirty}, 8'h01);
    pix(40, 10, 0, 1, 8'h00, "held_not_yet");
    commit_frame();
    pix(40, 10, 0, 1, 8'h77, "held_landed");

    // Out-of-range channel index is ignored
    wr(5, 3, 3, 8'hAA, 2'b01);
    wr(7, 3, 3, 8'hAB, 2'b01);
    commit_frame();
    pix(100, 100, 0, 1, 8'h00, "idx_ignored");

    // Outline in the last cell
    wr(3, 31, 15, 8'hF0, 2'b10);
    commit_frame();
    pix(992, 480, 0, 1, 8'hF0, "ol_corner");
    pix(1023, 500, 0, 1, 8'hF0, "ol_right");
    pix(1000, 511, 0, 1, 8'hF0, "ol_bottom");
    pix(992, 490, 0, 1, 8'hF0, "ol_left");
    pix(1000, 500, 0, 1, 8'h00, "ol_inside");
    pix(1010, 479, 0, 1, 8'h00, "ol_above");
    pix(1024, 500, 0, 1, 8'h00, "ol_no_wrap_h");
    pix(0, 490, 0, 1, 8'h00, "ol_col0");

    // Blink toggles every 16 commits
    wr(3, 31, 15, 8'hF0, 2'b11);
    commit_frame();
    pix(1000, 500, 0, 1, bcnt[4] ? 8'h00 : 8'hF0, "blink_a");
    repeat (16) commit_frame();
    pix(1000, 500, 0, 1, bcnt[4] ? 8'h00 : 8'hF0, "blink_b");
    repeat (16) commit_frame();
    pix(1000, 500, 0, 1, bcnt[4] ? 8'h00 : 8'hF0, "blink_c");

    // Mid-frame reset with a visible sprite and a pending write
    pix(10, 10, 0, 1, 8'h55, "pre_reset");
    pix(10, 10, 0, 1, 8'h55, "pre_reset2");
    wr(1, 4, 4, 8'h99, 2'b01);
    @(negedge clk);
    cmp("rgb_before_reset", rgbout, 8'h55);
    rst_n = 0; bcnt = 0;
    #1;
    cmp("rst_mid_rgb", rgbout, 8'h00);
    cmp("rst_mid_dirty", {7'd0, dirty}, 8'h00);
    @(negedge clk); rst_n = 1;
    commit_frame();
    pix(10, 10, 0, 1, 8'h00, "post_rst_ch1");
    pix(40, 10, 0, 1, 8'h00, "post_rst_ch2");
    pix(1000, 500, 0, 1, 8'h00, "post_rst_ch3");
    pix(140, 140, 0, 1, 8'h00, "post_rst_discard");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/grid_sprite_render.md
GRID_SPRITE_RENDER -- requirements
Module: grid_sprite_render

Interface
REQ-001 Parameter CELL_LOG2, default 5, meaning log2 of cell edge in pixels (5 gives 32x32 cells).
REQ-002 Parameter X_BITS, default 5, meaning width of cell column index.
REQ-003 Parameter Y_BITS, default 4, meaning width of cell row index.
REQ-004 Parameter NSPR, default 4, meaning sprite channel count (1..8).
REQ-005 Parameter BLINK_LOG2, default 4, meaning log2 of frames per blink half-period.
REQ-006 Port clk, input, 1 bit: the single pixel clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port hcount, input, 11 bits: current pixel column.
REQ-009 Port vcount, input, 11 bits: current pixel row.
REQ-010 Port blank, input, 1 bit: high outside the visible area.
REQ-011 Port wr_en, input, 1 bit: sprite register write request.
REQ-012 Port wr_idx, input, 3 bits: target channel; values >= NSPR are ignored but still handshaken.
REQ-013 Ports wr_x (X_BITS), wr_y (Y_BITS), wr_color (8), wr_mode (2): write data; mode 00 off, 01 solid, 10 outline, 11 blink.
REQ-014 Port wr_ready, output, 1 bit: a write is accepted on any cycle with wr_en and wr_ready both high.
REQ-015 Port dirty, output, 1 bit: high while shadow registers hold writes not yet committed.
REQ-016 Port rgbout, output, 8 bits: registered pixel colour.

Function
REQ-017 Each channel has a shadow register (x, y, color, mode) and an active register; accepted writes update only the shadow.
REQ-018 Commit event: the cycle with hcount==0 and vcount==0; all shadow registers are copied to active registers, dirty clears, and the blink frame counter increments (wraps modulo 2^(BLINK_LOG2+1)).
REQ-019 wr_ready is low exactly on the commit cycle and high otherwise; a wr_en held across the commit is accepted the following cycle and lands in the next frame.
REQ-020 dirty sets the cycle after any accepted write and holds until the next commit; a write and a commit never coincide.
REQ-021 Channel hit: hcount in [x*2^CELL_LOG2, (x+1)*2^CELL_LOG2 - 1] and vcount likewise for y, both bounds inclusive; comparisons are computed at 12 bits or wider so x or y at maximum never wraps.
REQ-022 Mode solid: hit. Mode outline: hit and (hcount or vcount low CELL_LOG2 bits all zero or all ones). Mode blink: hit and blink counter MSB == 0. Mode off: never hits.
REQ-023 Priority: the lowest-index channel that hits supplies the colour; no hit gives 8'h00.
REQ-024 Pipeline: stage 1 registers per-channel hit flags with blank; stage 2 registers the priority-selected colour into rgbout; latency is exactly 2 cycles from hcount/vcount/blank to rgbout.
REQ-025 rgbout is 8'h00 whenever the delayed blank is high, regardless of hits.
REQ-026 Active register changes at commit take effect for pixels presented from the cycle after commit; pixels already in the pipeline are unaffected.

Reset
REQ-027 While rst_n is low: all shadow and active registers are cleared (mode off, x=0, y=0, colour 0), blink counter 0, pipeline flags 0, rgbout 8'h00, dirty 0, wr_ready 1.
REQ-028 Reset asserted mid-frame or mid-write takes effect immediately; a write in progress is discarded; operation resumes on the first clock edge after rst_n rises.

Verification
REQ-029 Write ch0 x=2 y=1 colour 8'hE0 solid, run one frame -> rgbout 8'hE0 for h 64..95, v 32..63 two cycles delayed; 8'h00 at h=63 and h=96.
REQ-030 Ch0 solid 8'h1C and ch1 solid 8'h03, both at x=0 y=0 -> rgbout 8'h1C inside cell (ch0 wins); with ch0 set to off -> 8'h03.
REQ-031 Write during a frame -> dirty=1 and old colour displayed until h=0 v=0; new colour visible afterward; dirty=0 after commit.
REQ-032 wr_en held high across the commit cycle -> wr_ready=0 for that one cycle; write accepted the next cycle; dirty=1.
REQ-033 Outline mode at x=31 y=15, CELL_LOG2=5 -> colour only on cell border pixels (h 992 or 1023, v 480 or 511); no wrap to column 0; blink mode toggles visibility every 16 frames.
REQ-034 Assert rst_n low mid-frame with sprites active -> rgbout 8'h00 within the same cycle, dirty 0, all channels off after release.
